// File: rtl/dram_responder.sv
// AXI3 slave memory model for sim/emulation; INCR bursts, SLVERR on bad bursts/out-of-range beats; `DRAM_RESPONDER_BACKPRESSURE_EN adds LFSR stalls.
// Latency: first R beat R_LATENCY+1 cycles after AR handshake; WREADY the cycle after AW, BVALID the cycle after the final W beat.
// Backpressure: RVALID/BVALID held until accepted; with the macro defined, ready outputs and R launch are gated at ~75% duty.
module dram_responder #(
    parameter logic [31:0] ADDR_BASE = 32'h30000000,
    parameter int          MEM_WORDS = 4096,
    parameter int          R_LATENCY = 4
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [3:0]  S_AXI_ARLEN,
    input  logic [1:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [63:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [3:0]  S_AXI_AWLEN,
    input  logic [1:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [63:0] S_AXI_WDATA,
    input  logic [7:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY
);
    localparam int          IW          = $clog2(MEM_WORDS);
    localparam logic [31:0] WORDS_W     = 32'(MEM_WORDS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [63:0] mem [MEM_WORDS];

    // go_now gates decisions this cycle; go_next gates registered readies for the next cycle
    logic go_now, go_next;
`ifdef DRAM_RESPONDER_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign go_now  = (lfsr_q[1:0] != 2'b00);
    assign go_next = (lfsr_d[1:0] != 2'b00);
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign go_now  = 1'b1;
    assign go_next = 1'b1;
`endif

    // ---------------- read channel ----------------
    r_state_t    r_state_q, r_state_d;
    logic [31:0] r_idx_q, r_idx_d;
    logic [3:0]  r_left_q, r_left_d;
    logic        r_berr_q, r_berr_d;
    logic [7:0]  r_cnt_q, r_cnt_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rd_launch, r_beat_err;

    assign r_beat_err = r_berr_q || (r_idx_q >= WORDS_W);

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_left_d  = r_left_q;
        r_berr_d  = r_berr_q;
        r_cnt_d   = r_cnt_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_launch = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (arready_q && S_AXI_ARVALID) begin
                    r_state_d = R_WAIT;
                    r_idx_d   = (S_AXI_ARADDR - ADDR_BASE) >> 3;
                    r_left_d  = S_AXI_ARLEN;
                    r_berr_d  = (S_AXI_ARBURST != 2'b01) || (S_AXI_ARSIZE != 2'b11);
                    r_cnt_d   = 8'(R_LATENCY);
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 8'd0) rd_launch = go_now;
                else                 r_cnt_d   = r_cnt_q - 8'd1;
            end
            R_BURST: begin
                if (rvalid_q) begin
                    if (S_AXI_RREADY) begin
                        rvalid_d = 1'b0;
                        if (rlast_q) begin
                            rlast_d   = 1'b0;
                            r_state_d = R_IDLE;
                        end else begin
                            rd_launch = go_now;
                        end
                    end
                end else begin
                    rd_launch = go_now;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Array is read here, before any same-edge write commits, so a colliding read sees old data
        if (rd_launch) begin
            r_state_d = R_BURST;
            rvalid_d  = 1'b1;
            rlast_d   = (r_left_q == 4'd0);
            rdata_d   = r_beat_err ? 64'd0 : mem[r_idx_q[IW-1:0]];
            rresp_d   = r_beat_err ? RESP_SLVERR : RESP_OKAY;
            r_idx_d   = r_idx_q + 32'd1;
            r_left_d  = r_left_q - 4'd1;
        end
        arready_d = (r_state_d == R_IDLE) && go_next;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= 32'd0;
            r_left_q  <= 4'd0;
            r_berr_q  <= 1'b0;
            r_cnt_q   <= 8'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 64'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_left_q  <= r_left_d;
            r_berr_q  <= r_berr_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state_q, w_state_d;
    logic [31:0] w_idx_q, w_idx_d;
    logic [3:0]  w_left_q, w_left_d;
    logic        w_berr_q, w_berr_d;
    logic        w_err_q, w_err_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        wr_en, w_beat_err, w_beat_bad;

    assign w_beat_err = w_berr_q || (w_idx_q >= WORDS_W);
    // WLAST is only cross-checked against the beat count; it never ends the burst
    assign w_beat_bad = w_beat_err || (S_AXI_WLAST != (w_left_q == 4'd0));

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_left_d  = w_left_q;
        w_berr_d  = w_berr_q;
        w_err_d   = w_err_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awready_q && S_AXI_AWVALID) begin
                    w_state_d = W_DATA;
                    w_idx_d   = (S_AXI_AWADDR - ADDR_BASE) >> 3;
                    w_left_d  = S_AXI_AWLEN;
                    w_berr_d  = (S_AXI_AWBURST != 2'b01) || (S_AXI_AWSIZE != 2'b11);
                    w_err_d   = 1'b0;
                end
            end
            W_DATA: begin
                if (wready_q && S_AXI_WVALID) begin
                    wr_en   = !w_beat_err;
                    w_err_d = w_err_q || w_beat_bad;
                    w_idx_d = w_idx_q + 32'd1;
                    if (w_left_q == 4'd0) begin
                        w_state_d = W_RESP;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q || w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_left_d = w_left_q - 4'd1;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && go_next;
        wready_d  = (w_state_d == W_DATA) && go_next;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= 32'd0;
            w_left_q  <= 4'd0;
            w_berr_q  <= 1'b0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_left_q  <= w_left_d;
            w_berr_q  <= w_berr_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (S_AXI_WSTRB[i]) mem[w_idx_q[IW-1:0]][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: vector table of single-beat reads plus hand-written burst, error and reset sequences.
module tb_dram_responder;
    localparam logic [31:0] BASE = 32'h30000000;
    localparam logic [63:0] STEP = 64'h0101010101010101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ARADDR = '0;
    logic [3:0]  ARLEN = '0;
    logic [1:0]  ARSIZE = 2'b11, ARBURST = 2'b01;
    logic        ARVALID = 1'b0, ARREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID;
    logic        RREADY = 1'b1;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [1:0]  AWSIZE = 2'b11, AWBURST = 2'b01;
    logic        AWVALID = 1'b0, AWREADY;
    logic [63:0] WDATA = '0;
    logic [7:0]  WSTRB = '0;
    logic        WLAST = 1'b0, WVALID = 1'b0, WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dram_responder dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN), .S_AXI_ARSIZE(ARSIZE), .S_AXI_ARBURST(ARBURST),
        .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST), .S_AXI_RVALID(RVALID),
        .S_AXI_RREADY(RREADY),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWSIZE(AWSIZE), .S_AXI_AWBURST(AWBURST),
        .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST), .S_AXI_WVALID(WVALID),
        .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Burst data/strobes for writes, captured beats for reads
    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic [63:0] rd_d [16];
    logic [1:0]  rd_r [16];
    logic        rd_l [16];
    int          rd_n, rd_first, rd_hs;

    task automatic wr_burst(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input int flip, output logic [1:0] bresp);
        bit ok;
        @(negedge clk);
        AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = 2'b11; AWVALID = 1'b1;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (AWREADY) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("aw_handshake", 64'(ok), 64'd1);
        @(negedge clk);
        AWVALID = 1'b0;
        chk("wready_cycle_after_aw", 64'(WREADY), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            WDATA = wd[b]; WSTRB = ws[b];
            WLAST = ((b == int'(len)) != (b == flip));
            WVALID = 1'b1;
            ok = 0;
            for (int k = 0; k < 50; k++) begin
                if (WREADY) begin ok = 1; break; end
                @(negedge clk);
            end
            chk("w_handshake", 64'(ok), 64'd1);
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk("bvalid_cycle_after_last_w", 64'(BVALID), 64'd1);
        bresp = BRESP;
        BREADY = 1'b1;
        @(negedge clk);
        BREADY = 1'b0;
        chk("awready_after_b", 64'(AWREADY), 64'd1);
    endtask

    task automatic rd_burst(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [1:0] size, input bit toggle);
        bit ok, done, stall;
        logic [63:0] pd;
        logic [1:0]  pr;
        logic        pl;
        @(negedge clk);
        ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = size; ARVALID = 1'b1; RREADY = 1'b1;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (ARREADY) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("ar_handshake", 64'(ok), 64'd1);
        rd_hs = cyc + 1;
        @(negedge clk);
        ARVALID = 1'b0;
        rd_n = 0; rd_first = -1; done = 0; stall = 0;
        pd = '0; pr = '0; pl = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (stall)
                chk("r_stable_while_stalled", {RDATA[60:0], RVALID, RLAST, RRESP[1]} ^ 64'(RRESP[0]),
                    {pd[60:0], 1'b1, pl, pr[1]} ^ 64'(pr[0]));
            stall = 0;
            RREADY = toggle ? !RREADY : 1'b1;
            if (RVALID) begin
                if (rd_first < 0) rd_first = cyc;
                if (RREADY) begin
                    if (rd_n < 16) begin
                        rd_d[rd_n] = RDATA; rd_r[rd_n] = RRESP; rd_l[rd_n] = RLAST;
                    end
                    rd_n++;
                    if (RLAST) done = 1;
                end else begin
                    stall = 1; pd = RDATA; pr = RRESP; pl = RLAST;
                end
            end
            @(negedge clk);
        end
        RREADY = 1'b1;
        chk("r_burst_completed", 64'(done), 64'd1);
        chk("arready_after_last_r", 64'(ARREADY), 64'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [1:0]  size;
        logic [63:0] exp_d;
        logic [1:0]  exp_r;
    } vec_t;
    vec_t vt[11];

    initial begin
        logic [1:0] bresp;
        bit ok;
        vt[0]  = '{BASE,               2'b01, 2'b11, 64'h0,                 2'b00};
        vt[1]  = '{BASE + 32'h38,      2'b01, 2'b11, 64'h0707070707070707,  2'b00};
        vt[2]  = '{BASE + 32'h40,      2'b01, 2'b11, 64'h08080808FFFFFFFF,  2'b00};
        vt[3]  = '{BASE + 32'h48,      2'b01, 2'b11, 64'h0000000009090909,  2'b00};
        vt[4]  = '{BASE + 32'h78,      2'b01, 2'b11, 64'h0F0F0F0F0F0F0F0F,  2'b00};
        vt[5]  = '{BASE + 32'h45,      2'b01, 2'b11, 64'h08080808FFFFFFFF,  2'b00};
        vt[6]  = '{BASE - 32'h8,       2'b01, 2'b11, 64'h0,                 2'b10};
        vt[7]  = '{BASE + 32'h8000,    2'b01, 2'b11, 64'h0,                 2'b10};
        vt[8]  = '{BASE + 32'h38,      2'b00, 2'b11, 64'h0,                 2'b10};
        vt[9]  = '{BASE + 32'h38,      2'b01, 2'b10, 64'h0,                 2'b10};
        vt[10] = '{BASE + 32'h10,      2'b10, 2'b11, 64'h0,                 2'b10};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_wready",  64'(WREADY),  64'd0);
        chk("rst_rvalid",  64'(RVALID),  64'd0);
        chk("rst_rlast",   64'(RLAST),   64'd0);
        chk("rst_bvalid",  64'(BVALID),  64'd0);
        chk("rst_rdata",   RDATA,        64'd0);
        chk("rst_resp",    64'({RRESP, BRESP}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("arready_after_release", 64'(ARREADY), 64'd1);

        // Preload words 0..15, then stream them back
        for (int i = 0; i < 16; i++) begin wd[i] = STEP * 64'(i); ws[i] = 8'hFF; end
        wr_burst(BASE, 4'd15, 2'b01, -1, bresp);
        chk("preload_bresp", 64'(bresp), 64'd0);
        rd_burst(BASE, 4'd15, 2'b01, 2'b11, 1'b0);
        chk("rd16_first_rvalid_edge", 64'(rd_first), 64'(rd_hs + 5));
        chk("rd16_beats", 64'(rd_n), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk("rd16_data", rd_d[i], STEP * 64'(i));
            chk("rd16_resp", 64'(rd_r[i]), 64'd0);
            chk("rd16_last", 64'(rd_l[i]), 64'(i == 15));
        end

        // Strobed writes to words 8 and 9
        wd[0] = 64'hFFFFFFFFFFFFFFFF; ws[0] = 8'h0F;
        wd[1] = 64'h0;                ws[1] = 8'hF0;
        wr_burst(BASE + 32'h40, 4'd1, 2'b01, -1, bresp);
        chk("strobe_bresp", 64'(bresp), 64'd0);

        // Single-beat read vectors
        for (int i = 0; i < 11; i++) begin
            rd_burst(vt[i].addr, 4'd0, vt[i].burst, vt[i].size, 1'b0);
            chk("vec_beats", 64'(rd_n), 64'd1);
            chk("vec_data", rd_d[0], vt[i].exp_d);
            chk("vec_resp", 64'(rd_r[0]), 64'(vt[i].exp_r));
            chk("vec_last", 64'(rd_l[0]), 64'd1);
        end

        // Burst straddling the top of the array
        for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0A0A0A000000000 | 64'(i); ws[i] = 8'hFF; end
        wr_burst(BASE + 32'h7FF0, 4'd3, 2'b01, -1, bresp);
        chk("oob_wr_bresp", 64'(bresp), 64'd2);
        rd_burst(BASE + 32'h7FF0, 4'd3, 2'b01, 2'b11, 1'b0);
        chk("oob_rd_beats", 64'(rd_n), 64'd4);
        chk("oob_rd_d0", rd_d[0], 64'hA0A0A0A000000000);
        chk("oob_rd_d1", rd_d[1], 64'hA0A0A0A000000001);
        chk("oob_rd_r01", 64'({rd_r[0], rd_r[1]}), 64'd0);
        chk("oob_rd_d23", rd_d[2] | rd_d[3], 64'd0);
        chk("oob_rd_r23", 64'({rd_r[2], rd_r[3]}), 64'b1010);
        chk("oob_rd_last", 64'({rd_l[0], rd_l[1], rd_l[2], rd_l[3]}), 64'b0001);

        // FIXED burst write: accepted, nothing written
        wd[0] = 64'hDEADBEEFDEADBEEF; wd[1] = 64'hDEADBEEFDEADBEEF; ws[0] = 8'hFF; ws[1] = 8'hFF;
        wr_burst(BASE + 32'h8, 4'd1, 2'b00, -1, bresp);
        chk("fixed_bresp", 64'(bresp), 64'd2);
        rd_burst(BASE + 32'h8, 4'd1, 2'b01, 2'b11, 1'b0);
        chk("fixed_word1", rd_d[0], STEP);
        chk("fixed_word2", rd_d[1], STEP * 64'd2);

        // WLAST early on first of three beats, then WLAST missing on a single beat
        for (int i = 0; i < 3; i++) begin wd[i] = 64'hC0C0C0C0C0C0C0C0 + 64'(i); ws[i] = 8'hFF; end
        wr_burst(BASE + 32'h50, 4'd2, 2'b01, 0, bresp);
        chk("wlast_early_bresp", 64'(bresp), 64'd2);
        rd_burst(BASE + 32'h50, 4'd2, 2'b01, 2'b11, 1'b0);
        chk("wlast_early_word10", rd_d[0], 64'hC0C0C0C0C0C0C0C0);
        chk("wlast_early_word12", rd_d[2], 64'hC0C0C0C0C0C0C0C2);
        wr_burst(BASE + 32'h68, 4'd0, 2'b01, 0, bresp);
        chk("wlast_missing_bresp", 64'(bresp), 64'd2);

        // RREADY toggling every cycle over 8 beats
        rd_burst(BASE, 4'd7, 2'b01, 2'b11, 1'b1);
        chk("toggle_beats", 64'(rd_n), 64'd8);
        for (int i = 0; i < 8; i++) chk("toggle_data", rd_d[i], STEP * 64'(i));
        chk("toggle_last", 64'(rd_l[7]), 64'd1);

        // Reset in the middle of a read burst and a write burst
        @(negedge clk);
        ARADDR = BASE; ARLEN = 4'd15; ARBURST = 2'b01; ARSIZE = 2'b11; ARVALID = 1'b1; RREADY = 1'b0;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (ARREADY) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("mid_ar_handshake", 64'(ok), 64'd1);
        @(negedge clk);
        ARVALID = 1'b0;
        AWADDR = BASE + 32'hA0; AWLEN = 4'd3; AWBURST = 2'b01; AWSIZE = 2'b11; AWVALID = 1'b1;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (AWREADY) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("mid_aw_handshake", 64'(ok), 64'd1);
        @(negedge clk);
        AWVALID = 1'b0;
        for (int b = 0; b < 2; b++) begin
            WDATA = 64'h5555000000000000 | 64'(b); WSTRB = 8'hFF; WLAST = 1'b0; WVALID = 1'b1;
            ok = 0;
            for (int k = 0; k < 50; k++) begin
                if (WREADY) begin ok = 1; break; end
                @(negedge clk);
            end
            chk("mid_w_handshake", 64'(ok), 64'd1);
            @(negedge clk);
        end
        WVALID = 1'b0;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (RVALID) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("mid_rvalid_seen", 64'(ok), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", 64'(RVALID), 64'd0);
        chk("mid_rst_wready", 64'(WREADY), 64'd0);
        chk("mid_rst_arready", 64'(ARREADY), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_release_arready", 64'(ARREADY), 64'd0);
        @(negedge clk);
        chk("mid_arready_after_release", 64'(ARREADY), 64'd1);
        chk("mid_awready_after_release", 64'(AWREADY), 64'd1);
        chk("mid_bvalid_after_release", 64'(BVALID), 64'd0);
        RREADY = 1'b1;
        rd_burst(BASE + 32'hA0, 4'd1, 2'b01, 2'b11, 1'b0);
        chk("partial_write_word20", rd_d[0], 64'h5555000000000000);
        chk("partial_write_word21", rd_d[1], 64'h5555000000000001);
        rd_burst(BASE + 32'h40, 4'd0, 2'b01, 2'b11, 1'b0);
        chk("array_kept_word8", rd_d[0], 64'h08080808FFFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
